// File: rtl/booth_pkg.sv
// booth_pkg
// Shared definitions for the radix-4 Booth multiplier family.
//   state_t    : sequencer states (ST_IDLE, ST_RUN)
//   TRIP_*     : Booth triplet codes {q[i+1], q[i], q[i-1]}
//   pp_sel_t   : partial-product selection (zero, +M, +2M, -M, -2M)
//   booth_decode(triplet) -> pp_sel_t
package booth_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [2:0] TRIP_000 = 3'b000;
  localparam logic [2:0] TRIP_001 = 3'b001;
  localparam logic [2:0] TRIP_010 = 3'b010;
  localparam logic [2:0] TRIP_011 = 3'b011;
  localparam logic [2:0] TRIP_100 = 3'b100;
  localparam logic [2:0] TRIP_101 = 3'b101;
  localparam logic [2:0] TRIP_110 = 3'b110;
  localparam logic [2:0] TRIP_111 = 3'b111;

  typedef enum logic [2:0] {
    PP_ZERO = 3'd0,
    PP_P1   = 3'd1,
    PP_P2   = 3'd2,
    PP_N1   = 3'd3,
    PP_N2   = 3'd4
  } pp_sel_t;

  // Standard radix-4 recoding: each triplet selects one of five multiples.
  function automatic pp_sel_t booth_decode(input logic [2:0] triplet);
    case (triplet)
      TRIP_000, TRIP_111: return PP_ZERO;
      TRIP_001, TRIP_010: return PP_P1;
      TRIP_011:           return PP_P2;
      TRIP_100:           return PP_N2;
      TRIP_101, TRIP_110: return PP_N1;
      default:            return PP_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// booth_r4_encoder
// Combinational radix-4 Booth partial-product generator.
//   triplet : {q[i+1], q[i], q[i-1]} from the multiplier
//   m       : W-bit signed multiplicand
//   pp      : W+2-bit signed partial product (0, +/-M, +/-2M)
module booth_r4_encoder
  import booth_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [2:0]   triplet,
  input  logic [W-1:0] m,
  output logic [W+1:0] pp
);

  logic [W+1:0] m_ext;

  // Two guard bits keep +/-2M exact for any W-bit signed M.
  assign m_ext = {{2{m[W-1]}}, m};

  // Select the partial product for this triplet.
  always_comb begin
    pp = '0;
    case (booth_decode(triplet))
      PP_P1:   pp = m_ext;
      PP_P2:   pp = m_ext << 1;
      PP_N1:   pp = -m_ext;
      PP_N2:   pp = -(m_ext << 1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_multiplier.sv
// booth_r4_seq_multiplier
// Sequential radix-4 Booth multiplier retiring two multiplier bits per clock.
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   start         : request, sampled only while busy=0
//   is_signed     : 1 = two's-complement operands, 0 = unsigned
//   multiplicand  : N-bit operand M
//   multiplier    : N-bit operand Q
//   busy          : operation in progress
//   done          : one-cycle pulse, product valid
//   product       : 2N-bit result, held until the next completion
module booth_r4_seq_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           is_signed,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  import booth_pkg::*;

  // Two extra bits let unsigned operands be treated as positive signed values.
  localparam int W    = N + 2;
  localparam int ITER = W / 2;
  localparam int CW   = $clog2(ITER + 1);

  generate
    if ((N < 4) || ((N % 2) != 0)) begin : g_bad_n
      $error("booth_r4_seq_multiplier: N must be even and >= 4");
    end
  endgenerate

  state_t         state;
  logic [W+1:0]   acc;
  logic [W-1:0]   qx;
  logic           q_m1;
  logic [W-1:0]   mx;
  logic [CW-1:0]  count;
  logic [W+1:0]   pp;
  logic [W+1:0]   acc_sum;
  logic [2*W+2:0] shifted;

  booth_r4_encoder #(.W(W)) u_encoder (
    .triplet (({qx[1:0], q_m1})),
    .m       (mx),
    .pp      (pp)
  );

  // One iteration: accumulate the partial product, then shift {A,Qx,q_m1}
  // right by two with sign fill.
  always_comb begin
    acc_sum = acc + pp;
    shifted = $signed({acc_sum, qx, q_m1}) >>> 2;
  end

  // Sequencer and datapath registers. The final iteration writes the product
  // straight from the shifted value so done and product appear together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      qx      <= '0;
      q_m1    <= 1'b0;
      mx      <= '0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mx    <= is_signed ? {{2{multiplicand[N-1]}}, multiplicand} : {2'b00, multiplicand};
            qx    <= is_signed ? {{2{multiplier[N-1]}}, multiplier} : {2'b00, multiplier};
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= CW'(ITER);
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc   <= shifted[2*W+2:W+1];
          qx    <= shifted[W:1];
          q_m1  <= shifted[0];
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            product <= shifted[2*N:1];
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
// tb_booth_r4_seq_multiplier
// Drives an N=4 and an N=8 instance. A cycle-level model (pending-result
// countdown plus plain integer multiplication) is compared with both DUTs on
// every falling edge; directed cases also check hand-computed products.
module tb_booth_r4_seq_multiplier;

  localparam int ITER4 = 3;
  localparam int ITER8 = 5;
  localparam int NRAND = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, sg4;
  logic [3:0]  mc4, mq4;
  logic        busy4, done4;
  logic [7:0]  prod4;
  logic        start8, sg8;
  logic [7:0]  mc8, mq8;
  logic        busy8, done8;
  logic [15:0] prod8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_r4_seq_multiplier #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .is_signed(sg4),
    .multiplicand(mc4), .multiplier(mq4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  booth_r4_seq_multiplier #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sg8),
    .multiplicand(mc8), .multiplier(mq8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  // Exact product of two n-bit operands, truncated to 2n bits.
  function automatic logic [15:0] ref_mul(input int n, input logic sgn,
                                          input logic [7:0] a, input logic [7:0] b);
    longint av, bv, mask, half;
    logic [15:0] r;
    mask = (longint'(1) << n) - 1;
    half = longint'(1) << (n - 1);
    av = longint'(a) & mask;
    bv = longint'(b) & mask;
    if (sgn && av >= half) av = av - (longint'(1) << n);
    if (sgn && bv >= half) bv = bv - (longint'(1) << n);
    r = 16'(av * bv);
    if (n == 4) r = {8'h00, r[7:0]};
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: an accepted request yields its product after a fixed
  // number of busy cycles; requests while a result is pending are ignored.
  int          left  [2];
  logic        mbusy [2];
  logic        mdone [2];
  logic [15:0] mprod [2];
  logic [15:0] mpend [2];

  always @(posedge clk or posedge rst) begin : model_p
    logic st, sg;
    logic [7:0] a, b;
    int n, it;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        left[i] = 0; mbusy[i] = 1'b0; mdone[i] = 1'b0; mprod[i] = '0; mpend[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (i == 0) begin
          st = start4; sg = sg4; a = {4'h0, mc4}; b = {4'h0, mq4}; n = 4; it = ITER4;
        end else begin
          st = start8; sg = sg8; a = mc8; b = mq8; n = 8; it = ITER8;
        end
        mdone[i] = 1'b0;
        if (left[i] > 0) begin
          left[i]--;
          if (left[i] == 0) begin
            mdone[i] = 1'b1;
            mbusy[i] = 1'b0;
            mprod[i] = mpend[i];
          end
        end else if (st) begin
          mpend[i] = ref_mul(n, sg, a, b);
          left[i]  = it;
          mbusy[i] = 1'b1;
        end
      end
    end
  end

  // Compare both DUTs with the model on every falling edge outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("busy4", 64'(busy4), 64'(mbusy[0]));
      checkOutput("done4", 64'(done4), 64'(mdone[0]));
      checkOutput("prod4", 64'(prod4), 64'(mprod[0][7:0]));
      checkOutput("busy8", 64'(busy8), 64'(mbusy[1]));
      checkOutput("done8", 64'(done8), 64'(mdone[1]));
      checkOutput("prod8", 64'(prod8), 64'(mprod[1]));
    end
  end

  // Waits for done on the N=4 instance; start drops on the first cycle.
  task automatic waitDone4(output int cyc, output int bc);
    cyc = 0;
    bc  = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start4 = 1'b0; sg4 = 1'($urandom); mc4 = 4'($urandom); mq4 = 4'($urandom);
      end
      if (busy4) bc++;
    end while (!done4 && cyc < 20);
  endtask

  task automatic applyStimulus(input logic sgn, input logic [3:0] a, input logic [3:0] b,
                               input logic [7:0] expv, input string name);
    int cyc, bc;
    @(negedge clk);
    start4 = 1'b1; sg4 = sgn; mc4 = a; mq4 = b;
    waitDone4(cyc, bc);
    checkOutput({name, "_prod"}, 64'(prod4), 64'(expv));
    checkOutput({name, "_latency"}, 64'(cyc), 64'(4));
    checkOutput({name, "_busycycles"}, 64'(bc), 64'(3));
    checkOutput({name, "_model"}, 64'(ref_mul(4, sgn, {4'h0, a}, {4'h0, b})), 64'(expv));
  endtask

  initial begin : stim
    int cyc, bc, dc;
    rst = 1'b1;
    start4 = 1'b0; sg4 = 1'b0; mc4 = '0; mq4 = '0;
    start8 = 1'b0; sg8 = 1'b0; mc8 = '0; mq8 = '0;
    #1;
    checkOutput("reset_busy4", 64'(busy4), 64'(0));
    checkOutput("reset_done4", 64'(done4), 64'(0));
    checkOutput("reset_prod4", 64'(prod4), 64'(0));
    checkOutput("reset_busy8", 64'(busy8), 64'(0));
    checkOutput("reset_done8", 64'(done8), 64'(0));
    checkOutput("reset_prod8", 64'(prod8), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic signed and unsigned products, including the extreme corners.
    applyStimulus(1'b1, 4'd2, 4'd3, 8'h06, "s_2x3");
    applyStimulus(1'b1, 4'hB, 4'hA, 8'h1E, "s_m5xm6");
    applyStimulus(1'b1, 4'h8, 4'h8, 8'h40, "s_m8xm8");
    applyStimulus(1'b1, 4'h7, 4'h8, 8'hC8, "s_7xm8");
    applyStimulus(1'b0, 4'hF, 4'hF, 8'hE1, "u_15x15");
    applyStimulus(1'b0, 4'h8, 4'h8, 8'h40, "u_8x8");
    applyStimulus(1'b1, 4'hF, 4'hF, 8'h01, "s_m1xm1");

    // A request while busy is ignored; a request in the done cycle is taken.
    @(negedge clk);
    start4 = 1'b1; sg4 = 1'b1; mc4 = 4'd3; mq4 = 4'd5;
    @(negedge clk);
    start4 = 1'b1; sg4 = 1'b0; mc4 = 4'd7; mq4 = 4'd7;
    @(negedge clk);
    start4 = 1'b0;
    cyc = 2;
    while (!done4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("ignore_busy_prod", 64'(prod4), 64'(8'h0F));
    checkOutput("ignore_busy_latency", 64'(cyc), 64'(4));
    start4 = 1'b1; sg4 = 1'b0; mc4 = 4'd9; mq4 = 4'd11;
    waitDone4(cyc, bc);
    checkOutput("b2b_prod", 64'(prod4), 64'(8'h63));
    checkOutput("b2b_latency", 64'(cyc), 64'(4));

    // Reset in the second busy cycle aborts the operation.
    @(negedge clk);
    start4 = 1'b1; sg4 = 1'b1; mc4 = 4'd5; mq4 = 4'd5;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", 64'(busy4), 64'(0));
    checkOutput("abort_done", 64'(done4), 64'(0));
    checkOutput("abort_prod", 64'(prod4), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) dc++;
    end
    checkOutput("abort_no_done", 64'(dc), 64'(0));
    applyStimulus(1'b1, 4'hB, 4'hA, 8'h1E, "after_abort");

    // Random N=8 traffic, back-to-back, with ignored requests while busy.
    @(negedge clk);
    for (int k = 0; k < NRAND; k++) begin
      start8 = 1'b1;
      sg8    = 1'($urandom);
      mc8    = ((k % 16) == 0) ? 8'h80 : 8'($urandom);
      mq8    = ((k % 16) == 1) ? 8'hFF : 8'($urandom);
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (!done8) begin
          start8 = 1'($urandom); sg8 = 1'($urandom); mc8 = 8'($urandom); mq8 = 8'($urandom);
        end
      end while (!done8 && cyc < 20);
      if (!done8) checkOutput("done8_seen", 64'(done8), 64'(1));
    end
    start8 = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
